vga_sync_receiver: RTL
======================

Name: vga_sync_receiver

Overview:
- Receive-side counterpart of the VGA timing generator. Consumes hsync/vsync plus a pixel-rate strobe and recovers the pixel coordinates (h_pos, v_pos).
- Measures line length and frame length, and runs a lock state machine that asserts `locked` once the incoming timing matches 640x480@60 (800x525) for a set number of frames.
- Sits ahead of the frame-capture / image-processing path so it can check and realign an external or looped-back VGA stream.

Parameters:
- LOCK_FRAMES, 2, consecutive good frames required to enter LOCKED (1..15)
- TIMEOUT, 1024, pixel strobes without an hsync rising edge before loss of sync is declared
- H_SYNC_POS, 656, value loaded into h_pos on an hsync rising edge
- V_SYNC_POS, 490, value loaded into v_pos on a vsync rising edge

Ports:
- clk  in  1  100 MHz system clock
- btnC  in  1  reset, asynchronous, active-low
- pix_en  in  1  one-clk-wide pixel strobe (25 MHz rate); all protocol activity is qualified by it
- hsync_in  in  1  horizontal sync, active-high during retrace
- vsync_in  in  1  vertical sync, active-high during retrace
- h_pos  out  10  recovered horizontal position, 0..799
- v_pos  out  10  recovered vertical position, 0..524
- de  out  1  locked && h_pos<640 && v_pos<480
- h_total  out  11  last measured line length in strobes
- v_total  out  11  last measured frame length in lines
- locked  out  1  timing verified
- line_start  out  1  one-clk pulse on the pix_en where h_pos becomes 0
- frame_start  out  1  one-clk pulse on the pix_en where h_pos and v_pos both become 0
- sync_err  out  1  one-clk pulse on loss of lock or timeout

Behaviour:
- Reset (btnC=0, asynchronous): all outputs 0, all counters 0, FSM in SEARCH, edge history 0. Release takes effect on the next clk edge.
- Synchronisation:
  - hsync_in and vsync_in each pass through a 2-flop synchroniser on clk.
  - The previous sampled value updates only on pix_en.
  - Rise = pix_en && sync_s && !prev.
- h_pos:
  - On each pix_en, increments and wraps 799->0.
  - On hsync rise, h_pos is loaded with H_SYNC_POS instead of incrementing.
- v_pos:
  - Increments on the pix_en where h_pos wraps 799->0, and wraps 524->0.
  - On vsync rise, v_pos is loaded with V_SYNC_POS; this takes priority over the wrap increment.
- Line measurement:
  - h_len counts pix_en strobes and saturates at 2047.
  - On hsync rise: h_total<=h_len, h_len<=1.
  - line_err (sticky) is set if h_len != 800 at that rise, while in VERIFY or LOCKED, once at least one hsync rise has been seen since the last vsync rise.
- Frame measurement:
  - v_len counts hsync rises and saturates at 2047.
  - On vsync rise: v_total<=v_len, then v_len and line_err are cleared.
  - If hsync rise and vsync rise occur on the same pix_en, that line counts toward the frame that is ending.
- Timeout:
  - t_cnt counts pix_en strobes and clears on every hsync rise.
  - When t_cnt reaches TIMEOUT: FSM -> SEARCH, t_cnt cleared; sync_err pulses if the FSM was in LOCKED.
- Frame good = (v_len==525) && !line_err, evaluated at vsync rise.
- Lock FSM:
  - SEARCH: on vsync rise -> VERIFY, good_cnt<=0.
  - VERIFY: on vsync rise, a good frame increments good_cnt; a bad frame clears good_cnt and stays in VERIFY. When good_cnt reaches LOCK_FRAMES -> LOCKED.
  - LOCKED: a bad line (h_len!=800 at an hsync rise) or a bad frame -> SEARCH, sync_err pulse.
- locked is registered: it rises on the clk after the transition into LOCKED and falls on the clk of the transition out of LOCKED.
- line_start and frame_start are generated regardless of lock state.

Decomposition:
- vga_timing_pkg holds:
  - Timing constants: H_ACTIVE=640, H_TOTAL=800, H_SYNC_START=656, H_SYNC_END=751, V_ACTIVE=480, V_TOTAL=525, V_SYNC_START=490, V_SYNC_END=491.
  - Lock FSM state encoding (SEARCH, VERIFY, LOCKED).
  - The generator shares this package.
- One sub-module, vga_sync_edge: 2-flop synchroniser plus pix_en-qualified rising-edge detector; instantiated once for hsync and once for vsync.

Test Plan:
- Reset held 0 for 10 clk mid-stream -> all outputs 0, FSM in SEARCH; after release, locked stays 0 until lock is re-acquired.
- Nominal 800x525 stream from the generator, LOCK_FRAMES=2 -> locked rises after the 3rd vsync rise; h_total=800, v_total=525; de high for exactly 307200 strobes per locked frame, coinciding with the generator's display signal.
- After lock, one line stretched to 801 strobes -> a single sync_err pulse at that hsync rise, locked falls, h_total=801; relock after 3 more vsync rises.
- After lock, hsync held low for 1024 strobes -> sync_err pulse, locked=0; FSM in SEARCH.
- Frame with 524 lines in VERIFY -> v_total=524, good_cnt cleared, locked stays 0.
- hsync rise and vsync rise on the same pix_en -> v_total includes that line (525 for a nominal stream), v_pos=490, h_pos=656.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and lock-state encoding for the VGA
// timing generator and the sync receiver.
package vga_timing_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int H_TOTAL      = 800;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 751;
  localparam int V_ACTIVE     = 480;
  localparam int V_TOTAL      = 525;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 491;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lock_state_e;

endpackage

// File: rtl/vga_sync_receiver_edge.sv
// Two-flop synchroniser followed by a pix_en-qualified rising-edge detector.
// The edge history only advances on pixel strobes so a rise is seen once per
// pixel, independent of the clk/pixel ratio.
module vga_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic pix_en,
  input  logic sync_in,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // next-state of the synchroniser chain and the strobe-qualified history
  always_comb begin
    meta_d = sync_in;
    sync_d = meta_q;
    prev_d = prev_q;
    if (pix_en) begin
      prev_d = sync_q;
    end
  end

  // synchroniser and history registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = pix_en && sync_q && !prev_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers pixel coordinates from hsync/vsync, measures
// line and frame lengths and runs a lock state machine against the nominal
// timing. The geometry parameters default to 640x480@60 (800x525).
module vga_sync_receiver
  import vga_timing_pkg::*;
#(
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 1024,
  parameter int H_SYNC_POS  = H_SYNC_START,
  parameter int V_SYNC_POS  = V_SYNC_START,
  parameter int LINE_LEN    = H_TOTAL,
  parameter int FRAME_LINES = V_TOTAL,
  parameter int ACT_W       = H_ACTIVE,
  parameter int ACT_H       = V_ACTIVE
) (
  input  logic        clk,
  input  logic        btnC,
  input  logic        pix_en,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [9:0]  h_pos,
  output logic [9:0]  v_pos,
  output logic        de,
  output logic [10:0] h_total,
  output logic [10:0] v_total,
  output logic        locked,
  output logic        line_start,
  output logic        frame_start,
  output logic        sync_err
);

  localparam logic [9:0]  H_LAST   = 10'(LINE_LEN - 1);
  localparam logic [9:0]  V_LAST   = 10'(FRAME_LINES - 1);
  localparam logic [10:0] LEN_OK   = 11'(LINE_LEN);
  localparam logic [10:0] LINES_OK = 11'(FRAME_LINES);
  localparam logic [15:0] T_LAST   = 16'(TIMEOUT - 1);
  localparam logic [4:0]  LOCK_N   = 5'(LOCK_FRAMES);

  // Length counters stick at their maximum instead of wrapping.
  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  logic h_rise, v_rise;

  logic [9:0]  h_pos_q, h_pos_d, v_pos_q, v_pos_d;
  logic [10:0] h_len_q, h_len_d, v_len_q, v_len_d;
  logic [10:0] h_total_q, h_total_d, v_total_q, v_total_d;
  logic [15:0] t_cnt_q, t_cnt_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic        line_err_q, line_err_d, seen_h_q, seen_h_d;
  logic        locked_q, locked_d, sync_err_q, sync_err_d;
  logic        line_start_q, line_start_d, frame_start_q, frame_start_d;
  lock_state_e state_q, state_d;

  logic        h_wrap, line_bad, frame_good, timeout;
  logic [10:0] v_len_end;
  logic [4:0]  good_nxt;

  vga_sync_edge u_hsync (
    .clk    (clk),
    .rst_n  (btnC),
    .pix_en (pix_en),
    .sync_in(hsync_in),
    .rise   (h_rise)
  );

  vga_sync_edge u_vsync (
    .clk    (clk),
    .rst_n  (btnC),
    .pix_en (pix_en),
    .sync_in(vsync_in),
    .rise   (v_rise)
  );

  // position recovery, line/frame measurement and timeout counting
  always_comb begin
    h_pos_d       = h_pos_q;
    v_pos_d       = v_pos_q;
    h_len_d       = h_len_q;
    v_len_d       = v_len_q;
    h_total_d     = h_total_q;
    v_total_d     = v_total_q;
    t_cnt_d       = t_cnt_q;
    line_err_d    = line_err_q;
    seen_h_d      = seen_h_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    h_wrap        = 1'b0;
    line_bad      = 1'b0;
    frame_good    = 1'b0;
    timeout       = 1'b0;
    v_len_end     = v_len_q;
    if (pix_en) begin
      h_wrap = !h_rise && (h_pos_q == H_LAST);
      if (h_rise)      h_pos_d = 10'(H_SYNC_POS);
      else if (h_wrap) h_pos_d = 10'd0;
      else             h_pos_d = h_pos_q + 10'd1;
      // vsync realignment wins over the end-of-frame wrap
      if (v_rise)      v_pos_d = 10'(V_SYNC_POS);
      else if (h_wrap) v_pos_d = (v_pos_q == V_LAST) ? 10'd0 : v_pos_q + 10'd1;
      line_start_d  = h_wrap;
      frame_start_d = h_wrap && !v_rise && (v_pos_q == V_LAST);

      h_len_d = h_rise ? 11'd1 : sat_inc(h_len_q);
      if (h_rise) h_total_d = h_len_q;
      // the first line after vsync is partial, so it is not judged
      line_bad = h_rise && seen_h_q && (state_q != SEARCH) && (h_len_q != LEN_OK);
      // a line ending on the vsync strobe belongs to the frame that ends
      v_len_end  = h_rise ? sat_inc(v_len_q) : v_len_q;
      frame_good = (v_len_end == LINES_OK) && !line_err_q && !line_bad;
      if (v_rise) begin
        v_total_d  = v_len_end;
        v_len_d    = 11'd0;
        line_err_d = 1'b0;
        seen_h_d   = 1'b0;
      end else begin
        v_len_d = v_len_end;
        if (line_bad) line_err_d = 1'b1;
        if (h_rise)   seen_h_d   = 1'b1;
      end

      if (h_rise) begin
        t_cnt_d = 16'd0;
      end else if (t_cnt_q == T_LAST) begin
        timeout = 1'b1;
        t_cnt_d = 16'd0;
      end else begin
        t_cnt_d = t_cnt_q + 16'd1;
      end
    end
  end

  // lock state machine: next state, good-frame count and error pulse
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    sync_err_d = 1'b0;
    good_nxt   = {1'b0, good_cnt_q} + 5'd1;
    if (timeout) begin
      state_d    = SEARCH;
      sync_err_d = (state_q == LOCKED);
    end else begin
      case (state_q)
        SEARCH: begin
          if (v_rise) begin
            state_d    = VERIFY;
            good_cnt_d = 4'd0;
          end
        end
        VERIFY: begin
          if (v_rise) begin
            if (frame_good) begin
              good_cnt_d = good_nxt[3:0];
              if (good_nxt >= LOCK_N) state_d = LOCKED;
            end else begin
              good_cnt_d = 4'd0;
            end
          end
        end
        LOCKED: begin
          if (line_bad || (v_rise && !frame_good)) begin
            state_d    = SEARCH;
            sync_err_d = 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    // rises one clk after entering LOCKED, drops on the leaving edge itself
    locked_d = (state_q == LOCKED) && (state_d == LOCKED);
  end

  // lock state register
  always_ff @(posedge clk or negedge btnC) begin
    if (!btnC) begin
      state_q    <= SEARCH;
      good_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
    end
  end

  // counters, measurements and registered outputs
  always_ff @(posedge clk or negedge btnC) begin
    if (!btnC) begin
      h_pos_q       <= 10'd0;
      v_pos_q       <= 10'd0;
      h_len_q       <= 11'd0;
      v_len_q       <= 11'd0;
      h_total_q     <= 11'd0;
      v_total_q     <= 11'd0;
      t_cnt_q       <= 16'd0;
      line_err_q    <= 1'b0;
      seen_h_q      <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_pos_q       <= h_pos_d;
      v_pos_q       <= v_pos_d;
      h_len_q       <= h_len_d;
      v_len_q       <= v_len_d;
      h_total_q     <= h_total_d;
      v_total_q     <= v_total_d;
      t_cnt_q       <= t_cnt_d;
      line_err_q    <= line_err_d;
      seen_h_q      <= seen_h_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign h_pos       = h_pos_q;
  assign v_pos       = v_pos_q;
  assign h_total     = h_total_q;
  assign v_total     = v_total_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign de          = locked_q && (h_pos_q < 10'(ACT_W)) && (v_pos_q < 10'(ACT_H));

endmodule
